threshold_loader_lowampa: RTL and testbench
===========================================

# threshold_loader_lowampa

Host-side initiator for the low-amplitude beamformer's threshold cascade. It keeps a shadow copy of the two per-beam 18-bit thresholds: set 0 is the trigger threshold and set 1 is the servo threshold. On command, it streams every beam's value into the DSP cascade and then issues the update strobe. It drives the `thresh_i`, `thresh_wr_i` and `thresh_update_i` inputs of `beamform_trigger_lowampa` and sits between the register interface and the trigger core.

## Interface
Parameters:
- `NBEAMS`, 2: beams in the downstream cascade (1..64).
- `INIT_THRESH`, 18'h3FFFF: reset value of every shadow entry.
- `AUTOLOAD`, "TRUE": when "TRUE", a commit of both sets runs automatically after reset release.

Ports:
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `wr_en_i` in 1: shadow write strobe.
- `wr_set_i` in 1: set select; 0 = trigger, 1 = servo.
- `wr_addr_i` in clog2(NBEAMS): beam index.
- `wr_data_i` in 18: threshold value.
- `rd_set_i` in 1: readback set select.
- `rd_addr_i` in clog2(NBEAMS): readback beam index.
- `rd_data_o` out 18: registered shadow readback.
- `commit_i` in 2: per-set load request, one-cycle pulse.
- `busy_o` out 1: load sequence in progress.
- `done_o` out 1: one-cycle pulse when the sequence completes.
- `thresh_o` out 36: {set1[17:0], set0[17:0]}, to `thresh_i`.
- `thresh_wr_o` out 2: per-set cascade shift, to `thresh_wr_i`.
- `thresh_update_o` out 2: per-set apply strobe, to `thresh_update_i`.

## Operation
- Shadow storage:
  - 2×NBEAMS×18 bits.
  - Write-first on the host port.
  - Any host write with an out-of-range `wr_addr_i` (≥ NBEAMS) is ignored.
- Cascade contract:
  - Each `thresh_wr_o[s]` cycle shifts `thresh_o[s*18+:18]` into beam pair 0 and moves existing contents toward the last beam.
  - Values are therefore emitted in order beam NBEAMS-1 first, beam 0 last.
  - Exactly NBEAMS shifts are followed by one `thresh_update_o[s]` pulse.
- Pending mask:
  - `commit_i` is ORed into a 2-bit pending mask every cycle, including while busy.
  - The autoload request sets the mask to 2'b11 on the first cycle after reset deassertion.
- FSM states: IDLE, PREP, SHIFT, UPDATE.
- IDLE → PREP when the pending mask is nonzero:
  - The mask is copied into the active mask and the pending mask is cleared (commit_i in that same cycle is kept pending).
  - The beam counter is loaded with NBEAMS-1.
  - A shadow read of beam NBEAMS-1 is issued.
- PREP → SHIFT unconditionally.
- SHIFT:
  - `thresh_wr_o` = active mask.
  - `thresh_o` = registered read data for both sets; the inactive set's field is driven but not strobed.
  - Counter decrements each cycle.
  - → UPDATE after the beam-0 cycle.
- UPDATE:
  - `thresh_update_o` = active mask and `done_o` = 1 for one cycle.
  - → IDLE.
  - A new pending request is served from IDLE on the following cycle, never back-to-back.
- Shadow reads during a load:
  - The loader reads the shadow one cycle before each shift, read-old on address collision.
  - A host write to an entry in the same cycle it is read goes into the shadow but not into the current load.
- Reset mid-sequence: all outputs clear asynchronously and the shadow returns to INIT_THRESH. A partially shifted cascade is left unapplied because no update strobe is issued.

## Timing
- Reset values:
  - `thresh_o` = 0, `thresh_wr_o` = 0, `thresh_update_o` = 0.
  - `busy_o` = 0, `done_o` = 0, `rd_data_o` = INIT_THRESH.
- All outputs are registered.
- With `commit_i` high at edge 0 in IDLE:
  - `busy_o` rises at edge 1 (PREP).
  - `thresh_wr_o` is high on edges 2..NBEAMS+1.
  - `thresh_update_o` and `done_o` are high at edge NBEAMS+2.
  - `busy_o` falls at edge NBEAMS+3.
- Sequence length is NBEAMS+2 busy cycles.
- `rd_data_o`: one-cycle latency. A same-cycle host write to the read address returns the new value.

## Structure
- Package `threshold_loader_pkg`:
  - `THRESH_BITS` = 18, `NSETS` = 2.
  - `typedef enum logic [1:0] {IDLE, PREP, SHIFT, UPDATE} loader_state_t`.
- Sub-module `threshold_shadow_regs`:
  - Dual-set register file with async reset to INIT_THRESH.
  - One host write port, a registered host read port, and a registered loader read port.
- Top level holds the FSM, the pending/active masks and the beam counter.

## Test plan
- NBEAMS=4, AUTOLOAD="TRUE": release reset → the cascade model sees set0/set1 shifts of 3FFFF ×4, then update=2'b11 at cycle 6; `done_o` pulses once.
- Write set0 beams 0..3 = 100,200,300,400; pulse commit=2'b01 → `thresh_wr_o`=2'b01 with values 400,300,200,100 on cycles 2–5; update=2'b01 at cycle 6; the set1 model is unchanged.
- commit=2'b10 pulsed during SHIFT of a set-0 load → after UPDATE, one IDLE cycle, then a set-1-only sequence runs.
- Host write to beam 2 on the cycle its shadow read is issued → the old value is shifted; the next commit shifts the new value.
- Assert `rst_n_i` low during SHIFT → all outputs are 0 asynchronously, no update strobe; after release, a fresh autoload completes.
- NBEAMS=1: commit=2'b11 → one shift cycle, update at edge 3.

Source files
------------

// File: rtl/threshold_loader_lowampa_pkg.sv
// rtl/threshold_loader_lowampa_pkg.sv - shared widths, loader states and address sizing helper
package threshold_loader_pkg;

    localparam int THRESH_BITS = 18;
    localparam int NSETS       = 2;

    typedef enum logic [1:0] {IDLE, PREP, SHIFT, UPDATE} loader_state_t;

    // A single-beam cascade still needs a one-bit address port.
    function automatic int addr_bits(input int nbeams);
        return (nbeams > 1) ? $clog2(nbeams) : 1;
    endfunction

endpackage

// File: rtl/threshold_loader_lowampa_if.sv
// rtl/threshold_loader_lowampa_if.sv - host register port of the threshold loader
interface threshold_loader_lowampa_if
    import threshold_loader_pkg::*;
#(
    parameter int NBEAMS = 2
);
    localparam int AW = addr_bits(NBEAMS);

    logic                   wr_en_i;
    logic                   wr_set_i;
    logic [AW-1:0]          wr_addr_i;
    logic [THRESH_BITS-1:0] wr_data_i;
    logic                   rd_set_i;
    logic [AW-1:0]          rd_addr_i;
    logic [THRESH_BITS-1:0] rd_data_o;

    modport master (
        output wr_en_i, wr_set_i, wr_addr_i, wr_data_i, rd_set_i, rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i, wr_set_i, wr_addr_i, wr_data_i, rd_set_i, rd_addr_i,
        output rd_data_o
    );

endinterface

// File: rtl/threshold_loader_lowampa_shadow.sv
// rtl/threshold_loader_lowampa_shadow.sv - dual-set threshold shadow with host and loader read ports
module threshold_shadow_regs
    import threshold_loader_pkg::*;
#(
    parameter int                     NBEAMS      = 2,
    parameter logic [THRESH_BITS-1:0] INIT_THRESH = 18'h3FFFF,
    localparam int                    AW          = addr_bits(NBEAMS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic                     wr_set_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [THRESH_BITS-1:0]   wr_data_i,
    input  logic                     rd_set_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic [THRESH_BITS-1:0]   rd_data_o,
    input  logic                     ld_en_i,
    input  logic [AW-1:0]            ld_addr_i,
    output logic [2*THRESH_BITS-1:0] ld_data_o
);

    logic [THRESH_BITS-1:0]   mem_q [NSETS][NBEAMS];
    logic [THRESH_BITS-1:0]   rd_q;
    logic [2*THRESH_BITS-1:0] ld_q;
    logic                     wr_ok;
    logic                     rd_ok;
    logic                     rd_hit;

    assign wr_ok  = wr_en_i && (32'(wr_addr_i) < NBEAMS);
    assign rd_ok  = 32'(rd_addr_i) < NBEAMS;
    assign rd_hit = wr_ok && (wr_set_i == rd_set_i) && (wr_addr_i == rd_addr_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < NSETS; s++) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    mem_q[s][b] <= INIT_THRESH;
                end
            end
        end else if (wr_ok) begin
            mem_q[wr_set_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Host readback is write-first; the loader port sees the pre-write contents.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q <= INIT_THRESH;
        end else if (rd_hit) begin
            rd_q <= wr_data_i;
        end else if (rd_ok) begin
            rd_q <= mem_q[rd_set_i][rd_addr_i];
        end else begin
            rd_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ld_q <= '0;
        end else if (ld_en_i) begin
            ld_q <= {mem_q[1][ld_addr_i], mem_q[0][ld_addr_i]};
        end
    end

    assign rd_data_o = rd_q;
    assign ld_data_o = ld_q;

endmodule

// File: rtl/threshold_loader_lowampa.sv
// rtl/threshold_loader_lowampa.sv - streams shadow thresholds into the trigger cascade, then strobes update
module threshold_loader_lowampa
    import threshold_loader_pkg::*;
#(
    parameter int                     NBEAMS      = 2,
    parameter logic [THRESH_BITS-1:0] INIT_THRESH = 18'h3FFFF,
    parameter string                  AUTOLOAD    = "TRUE",
    localparam int                    AW          = addr_bits(NBEAMS)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    threshold_loader_lowampa_if.slave        host,
    input  logic [1:0]                       commit_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [2*THRESH_BITS-1:0]         thresh_o,
    output logic [1:0]                       thresh_wr_o,
    output logic [1:0]                       thresh_update_o
);

    localparam bit            AUTO_EN   = (AUTOLOAD == "TRUE");
    localparam logic [AW-1:0] LAST_BEAM = AW'(NBEAMS - 1);

    loader_state_t            state_q, state_d;
    logic [1:0]               pending_q, pending_d;
    logic [1:0]               active_q, active_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic                     boot_q;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [1:0]               wr_q, wr_d;
    logic [1:0]               upd_q, upd_d;
    logic                     ld_en;
    logic [AW-1:0]            ld_addr;
    logic [2*THRESH_BITS-1:0] ld_data;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | commit_i | {2{boot_q & AUTO_EN}};
        active_d  = active_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_d      = 2'b00;
        upd_d     = 2'b00;
        ld_en     = 1'b0;
        ld_addr   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q != 2'b00) begin
                    state_d   = PREP;
                    active_d  = pending_q;
                    pending_d = commit_i;
                    cnt_d     = LAST_BEAM;
                    busy_d    = 1'b1;
                end
            end
            PREP: begin
                state_d = SHIFT;
                ld_en   = 1'b1;
                wr_d    = active_q;
            end
            SHIFT: begin
                // The fetch for the next beam overlaps the current shift cycle.
                if (cnt_q == '0) begin
                    state_d = UPDATE;
                    upd_d   = active_q;
                    done_d  = 1'b1;
                end else begin
                    ld_en   = 1'b1;
                    ld_addr = cnt_q - AW'(1);
                    cnt_d   = cnt_q - AW'(1);
                    wr_d    = active_q;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            pending_q <= 2'b00;
            active_q  <= 2'b00;
            cnt_q     <= '0;
            boot_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 2'b00;
            upd_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            boot_q    <= 1'b0;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            upd_q     <= upd_d;
        end
    end

    threshold_shadow_regs #(
        .NBEAMS      (NBEAMS),
        .INIT_THRESH (INIT_THRESH)
    ) u_shadow (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (host.wr_en_i),
        .wr_set_i  (host.wr_set_i),
        .wr_addr_i (host.wr_addr_i),
        .wr_data_i (host.wr_data_i),
        .rd_set_i  (host.rd_set_i),
        .rd_addr_i (host.rd_addr_i),
        .rd_data_o (host.rd_data_o),
        .ld_en_i   (ld_en),
        .ld_addr_i (ld_addr),
        .ld_data_o (ld_data)
    );

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign thresh_o        = ld_data;
    assign thresh_wr_o     = wr_q;
    assign thresh_update_o = upd_q;

endmodule

// File: tb/tb_threshold_loader_lowampa.sv
// tb/tb_threshold_loader_lowampa.sv - randomized bench with timeline model and downstream cascade model
module tb_threshold_loader_lowampa;
    import threshold_loader_pkg::*;

    localparam int          N    = 4;
    localparam logic [17:0] INIT = 18'h3FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    threshold_loader_lowampa_if #(.NBEAMS(N)) hif0 ();
    threshold_loader_lowampa_if #(.NBEAMS(1)) hif1 ();

    logic [1:0]  commit0, commit1, wr0, upd0, wr1, upd1;
    logic        busy0, done0, busy1, done1;
    logic [35:0] th0, th1;

    threshold_loader_lowampa #(.NBEAMS(N), .INIT_THRESH(INIT), .AUTOLOAD("TRUE")) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .host(hif0.slave), .commit_i(commit0),
        .busy_o(busy0), .done_o(done0), .thresh_o(th0),
        .thresh_wr_o(wr0), .thresh_update_o(upd0)
    );

    threshold_loader_lowampa #(.NBEAMS(1), .INIT_THRESH(INIT), .AUTOLOAD("FALSE")) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .host(hif1.slave), .commit_i(commit1),
        .busy_o(busy1), .done_o(done1), .thresh_o(th1),
        .thresh_wr_o(wr1), .thresh_update_o(upd1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Timeline model: a load occupies N+2 cycles counted from the edge it starts on.
    logic [17:0] m_sh [2][N];
    logic [17:0] m_old [2][N];
    logic [1:0]  m_pend, m_act, m_wr, m_upd;
    logic        m_busy, m_done, m_boot;
    logic [35:0] m_th;
    logic [17:0] m_rd;
    int          m_p;
    bit          m_inseq;
    int          e_idx;
    int          first_upd = -1;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < N; b++) m_sh[s][b] = INIT;
            m_pend = 0; m_act = 0; m_inseq = 0; m_p = 0; m_boot = 1'b1;
            m_busy = 0; m_done = 0; m_wr = 0; m_upd = 0; m_rd = INIT; m_th = '0;
            e_idx = -1;
        end else begin
            e_idx++;
            m_old = m_sh;
            if (hif0.wr_en_i) m_sh[hif0.wr_set_i][hif0.wr_addr_i] = hif0.wr_data_i;
            m_rd = m_sh[hif0.rd_set_i][hif0.rd_addr_i];
            m_wr = 0; m_upd = 0; m_done = 0;
            if (m_inseq) begin
                m_p++;
                if (m_p == N + 2) m_inseq = 0;
                else if (m_p <= N) begin
                    m_wr = m_act;
                    m_th = {m_old[1][N - m_p], m_old[0][N - m_p]};
                end else begin
                    m_upd = m_act;
                    m_done = 1'b1;
                end
                m_pend = m_pend | commit0 | {2{m_boot}};
            end else if (m_pend != 0) begin
                m_act = m_pend;
                m_pend = commit0;
                m_inseq = 1;
                m_p = 0;
            end else begin
                m_pend = m_pend | commit0 | {2{m_boot}};
            end
            m_boot = 1'b0;
            m_busy = m_inseq;
        end
        #1;
        chk("busy", 64'(busy0), 64'(m_busy));
        chk("done", 64'(done0), 64'(m_done));
        chk("thresh_wr", 64'(wr0), 64'(m_wr));
        chk("thresh_update", 64'(upd0), 64'(m_upd));
        chk("rd_data", 64'(hif0.rd_data_o), 64'(m_rd));
        if (m_wr != 0) chk("thresh", 64'(th0), 64'(m_th));
        if (upd0 != 0 && first_upd < 0) first_upd = e_idx;
    end

    // Downstream cascade: shift into beam 0, apply on update.
    logic [17:0] casc [2][N];
    logic [17:0] appl [2][N];
    int          n_done = 0;

    initial begin
        for (int s = 0; s < 2; s++)
            for (int b = 0; b < N; b++) begin casc[s][b] = '0; appl[s][b] = '0; end
    end

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wr0[s]) begin
                for (int b = N - 1; b > 0; b--) casc[s][b] = casc[s][b-1];
                casc[s][0] = th0[s*18 +: 18];
            end
            if (upd0[s]) appl[s] = casc[s];
        end
        if (done0) n_done++;
    end

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (n_done < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(n_done), 64'(target));
    endtask

    task automatic wait_shift();
        int k = 0;
        while (wr0 == 2'b00 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("shift_seen", 64'(wr0 != 2'b00), 64'(1));
    endtask

    task automatic host_wr(input logic set, input logic [1:0] addr, input logic [17:0] data);
        @(negedge clk);
        hif0.wr_en_i = 1'b1; hif0.wr_set_i = set; hif0.wr_addr_i = addr; hif0.wr_data_i = data;
        @(negedge clk);
        hif0.wr_en_i = 1'b0;
    endtask

    task automatic pulse_commit(input logic [1:0] m);
        @(negedge clk);
        commit0 = m;
        @(negedge clk);
        commit0 = 2'b00;
    endtask

    initial begin
        int base;
        int n_sh1;
        int upd_edge1;
        hif0.wr_en_i = 0; hif0.wr_set_i = 0; hif0.wr_addr_i = 0; hif0.wr_data_i = 0;
        hif0.rd_set_i = 0; hif0.rd_addr_i = 0; commit0 = 0;
        hif1.wr_en_i = 0; hif1.wr_set_i = 0; hif1.wr_addr_i = 0; hif1.wr_data_i = 0;
        hif1.rd_set_i = 0; hif1.rd_addr_i = 0; commit1 = 0;

        repeat (3) @(negedge clk);
        chk("rst_thresh", 64'(th0), 64'(0));
        chk("rst_wr", 64'(wr0), 64'(0));
        chk("rst_update", 64'(upd0), 64'(0));
        chk("rst_busy", 64'(busy0), 64'(0));
        chk("rst_done", 64'(done0), 64'(0));
        chk("rst_rd_data", 64'(hif0.rd_data_o), 64'(INIT));
        rst_n = 1'b1;

        // Autoload after release
        wait_done(1, "autoload_done");
        repeat (3) @(negedge clk);
        chk("autoload_update_edge", 64'(first_upd), 64'(6));
        for (int b = 0; b < N; b++) begin
            chk("autoload_set0", 64'(appl[0][b]), 64'(INIT));
            chk("autoload_set1", 64'(appl[1][b]), 64'(INIT));
        end

        // Single-beam instance: one shift, update on edge 3
        n_sh1 = 0; upd_edge1 = -1;
        @(negedge clk);
        commit1 = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) commit1 = 2'b00;
            if (wr1 == 2'b11) begin
                n_sh1++;
                chk("nb1_thresh", 64'(th1), 64'({INIT, INIT}));
            end
            if (upd1 == 2'b11) upd_edge1 = k;
        end
        chk("nb1_shifts", 64'(n_sh1), 64'(1));
        chk("nb1_update_edge", 64'(upd_edge1), 64'(3));
        chk("nb1_idle", 64'(busy1), 64'(0));

        // Set-0 load of 100..400
        for (int b = 0; b < N; b++) host_wr(1'b0, 2'(b), 18'(100 * (b + 1)));
        pulse_commit(2'b01);
        wait_done(2, "set0_done");
        repeat (2) @(negedge clk);
        for (int b = 0; b < N; b++) begin
            chk("set0_applied", 64'(appl[0][b]), 64'(100 * (b + 1)));
            chk("set1_untouched", 64'(appl[1][b]), 64'(INIT));
        end

        // Set-1 request arriving mid-load is served after one idle cycle
        for (int b = 0; b < N; b++) host_wr(1'b1, 2'(b), 18'(11 * (b + 1)));
        @(negedge clk);
        commit0 = 2'b01;
        @(negedge clk);
        commit0 = 2'b00;
        wait_shift();
        @(negedge clk);
        commit0 = 2'b10;
        @(negedge clk);
        commit0 = 2'b00;
        wait_done(4, "queued_done");
        repeat (2) @(negedge clk);
        for (int b = 0; b < N; b++)
            chk("set1_applied", 64'(appl[1][b]), 64'(11 * (b + 1)));

        // Host write to beam 2 on the edge its loader read happens
        @(negedge clk);
        commit0 = 2'b01;
        @(negedge clk);
        commit0 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        hif0.wr_en_i = 1'b1; hif0.wr_set_i = 1'b0; hif0.wr_addr_i = 2'd2; hif0.wr_data_i = 18'd777;
        @(negedge clk);
        hif0.wr_en_i = 1'b0;
        wait_done(5, "collide_done");
        repeat (2) @(negedge clk);
        chk("collide_old_value", 64'(appl[0][2]), 64'(300));
        pulse_commit(2'b01);
        wait_done(6, "recommit_done");
        repeat (2) @(negedge clk);
        chk("recommit_new_value", 64'(appl[0][2]), 64'(777));

        // Asynchronous reset in the middle of SHIFT
        pulse_commit(2'b11);
        wait_shift();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_thresh", 64'(th0), 64'(0));
        chk("midrst_wr", 64'(wr0), 64'(0));
        chk("midrst_update", 64'(upd0), 64'(0));
        chk("midrst_busy", 64'(busy0), 64'(0));
        chk("midrst_done", 64'(done0), 64'(0));
        chk("midrst_rd_data", 64'(hif0.rd_data_o), 64'(INIT));
        base = n_done;
        repeat (2) @(negedge clk);
        chk("midrst_no_apply", 64'(appl[0][2]), 64'(777));
        chk("midrst_no_done", 64'(n_done), 64'(base));
        rst_n = 1'b1;
        wait_done(base + 1, "reautoload_done");
        repeat (3) @(negedge clk);
        for (int b = 0; b < N; b++) begin
            chk("reautoload_set0", 64'(appl[0][b]), 64'(INIT));
            chk("reautoload_set1", 64'(appl[1][b]), 64'(INIT));
        end

        // Random traffic against the timeline model
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            hif0.wr_en_i   = ($urandom_range(3) == 0);
            hif0.wr_set_i  = 1'($urandom_range(1));
            hif0.wr_addr_i = 2'($urandom_range(N - 1));
            hif0.wr_data_i = 18'($urandom);
            hif0.rd_set_i  = 1'($urandom_range(1));
            hif0.rd_addr_i = 2'($urandom_range(N - 1));
            commit0        = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'b00;
        end
        @(negedge clk);
        hif0.wr_en_i = 1'b0;
        commit0 = 2'b00;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
